// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback path.
// Holds default widths, the load-size encoding and the load align/extend function.
package wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } ld_size_e;

    // Little-endian lane select followed by sign/zero extension.
    // Size 2'b11 falls into the word path. Halfword ignores off[0].
    function automatic logic [DEF_DATA_W-1:0] align_extend(
        input logic [DEF_DATA_W-1:0] raw,
        input logic [1:0]            size,
        input logic                  sext,
        input logic [1:0]            off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = raw[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return {{24{sext & b[7]}}, b};
            SZ_HALF: return {{16{sext & h[15]}}, h};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_queue.sv
// Synchronous FIFO for load results awaiting the register-file write port.
// Ports: clk, reset (async low), push/push_data, pop/pop_data, full, empty.
module wb_load_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-port controller: merges ALU and load results, one write per cycle.
// Ports: clk, reset (async low); alu_valid/alu_rd/alu_data; ld_issue/ld_issue_rd;
//  ld_valid/ld_ready/ld_rd/ld_data/ld_size/ld_signed/ld_offset; wb_we/wb_rd/wb_data;
//  pending_mask (outstanding loads per register); waw_err (sticky ALU-over-pending-load).
module regfile_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_rd,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [1:0]        ld_offset,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       pending_mask,
    output logic              waw_err
);

    localparam int ENT_W = ADDR_W + DATA_W;

    logic              lq_full;
    logic              lq_empty;
    logic              lq_push;
    logic              lq_pop;
    logic [ENT_W-1:0]  lq_in;
    logic [ENT_W-1:0]  lq_head;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] aligned;
    logic              alu_win;
    logic [31:0]       set_vec;
    logic [31:0]       clr_vec;
    logic [31:0]       pending_nxt;

    // ld_ready reflects registered occupancy only; a same-cycle pop does not free a slot.
    assign ld_ready = !lq_full;

    // Loads targeting x0 are consumed but never queued.
    assign lq_push = ld_valid && ld_ready && (ld_rd != '0);
    assign aligned = align_extend(ld_data, ld_size, ld_signed, ld_offset);
    assign lq_in   = {ld_rd, aligned};

    assign {head_rd, head_data} = lq_head;

    // An ALU result to x0 is not a request, letting a queued load use the port.
    assign alu_win = alu_valid && (alu_rd != '0);
    assign lq_pop  = !alu_win && !lq_empty;

    wb_load_queue #(
        .DEPTH (LQ_DEPTH),
        .WIDTH (ENT_W)
    ) u_lq (
        .clk       (clk),
        .reset     (reset),
        .push      (lq_push),
        .push_data (lq_in),
        .pop       (lq_pop),
        .pop_data  (lq_head),
        .full      (lq_full),
        .empty     (lq_empty)
    );

    // Set beats clear on the same bit; x0 never shows as pending.
    always_comb begin
        set_vec     = '0;
        clr_vec     = '0;
        if (ld_issue) begin
            set_vec = 32'd1 << ld_issue_rd;
        end
        if (lq_pop) begin
            clr_vec = 32'd1 << head_rd;
        end
        pending_nxt = ((pending_mask & ~clr_vec) | set_vec) & ~32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            pending_mask <= '0;
            waw_err      <= 1'b0;
        end else begin
            pending_mask <= pending_nxt;
            if (alu_win) begin
                wb_we   <= 1'b1;
                wb_rd   <= alu_rd;
                wb_data <= alu_data;
                if (pending_mask[alu_rd]) begin
                    waw_err <= 1'b1;
                end
            end else if (lq_pop) begin
                wb_we   <= 1'b1;
                wb_rd   <= head_rd;
                wb_data <= head_data;
            end else begin
                wb_we   <= 1'b0;
            end
        end
    end

endmodule
